interpolator_intensity: RTL

- Consumer end of the intensity silencer step stream: takes per-transducer target INTENSITY plus the UPDATE_RATE produced by the step calculator and moves each transducer's stored current intensity toward its target by at most UPDATE_RATE per frame.
- Sits between the step calculator and the modulation/pulse-width stage.
- Emits the smoothed intensity stream in transducer order.

---
 rtl/silencer_pkg.sv | 20 ++
 rtl/interp_step.sv | 99 +++++++++
 rtl/interpolator_intensity.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/silencer_pkg.sv
// Shared types and constants for the intensity silencer interpolator.
// Optional build macro: SILENCER_BYPASS_EN (adds a per-entry BYPASS input).
package silencer_pkg;

    // Controller states: CLEAR zeroes the current-value memory, RUN accepts entries.
    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } interp_state_t;

    // Cycles from an accepted entry to its DOUT_VALID pulse.
    localparam int LATENCY = 3;

    // Size of the current-value memory (one word per possible transducer).
    localparam int MEM_WORDS = 256;

    // One intensity word.
    typedef logic [15:0] intensity_t;

endpackage

// File: rtl/interp_step.sv
// Registered S2/S3 datapath: compares target with the stored current value
// and moves current toward target by at most rate, never overshooting.
// Optional build macro: SILENCER_BYPASS_EN (snap straight to target).
module interp_step (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        valid_i,
    input  logic [15:0] current_i,
    input  logic [15:0] target_i,
    input  logic [15:0] rate_i,
`ifdef SILENCER_BYPASS_EN
    input  logic        bypass_i,
`endif
    output logic        valid_o,
    output logic [15:0] next_o
);
    import silencer_pkg::*;

    logic       s2_valid_q;
    logic       s2_up_q;
    intensity_t s2_diff_q;
    intensity_t s2_cur_q;
    intensity_t s2_tgt_q;
    intensity_t s2_rate_q;
`ifdef SILENCER_BYPASS_EN
    logic       s2_byp_q;
`endif

    logic       up_d;
    intensity_t diff_d;
    logic       snap_d;
    intensity_t next_d;
    logic       valid_q;
    intensity_t next_q;

    // S2 compare: direction and magnitude of the gap, both unsigned so nothing wraps.
    always_comb begin
        up_d   = target_i > current_i;
        diff_d = up_d ? (target_i - current_i) : (current_i - target_i);
    end

    // S2 register: hold the operands alongside the compare result.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s2_valid_q <= 1'b0;
            s2_up_q    <= 1'b0;
            s2_diff_q  <= '0;
            s2_cur_q   <= '0;
            s2_tgt_q   <= '0;
            s2_rate_q  <= '0;
`ifdef SILENCER_BYPASS_EN
            s2_byp_q   <= 1'b0;
`endif
        end else begin
            s2_valid_q <= valid_i;
            s2_up_q    <= up_d;
            s2_diff_q  <= diff_d;
            s2_cur_q   <= current_i;
            s2_tgt_q   <= target_i;
            s2_rate_q  <= rate_i;
`ifdef SILENCER_BYPASS_EN
            s2_byp_q   <= bypass_i;
`endif
        end
    end

    // S3 step: snap to target when the step would reach or pass it, else move by rate.
    always_comb begin
`ifdef SILENCER_BYPASS_EN
        snap_d = s2_byp_q || (s2_rate_q >= s2_diff_q);
`else
        snap_d = s2_rate_q >= s2_diff_q;
`endif
        if (snap_d) begin
            next_d = s2_tgt_q;
        end else if (s2_up_q) begin
            next_d = s2_cur_q + s2_rate_q;
        end else begin
            next_d = s2_cur_q - s2_rate_q;
        end
    end

    // S3 register: publish the new value; hold the last value between entries.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            next_q  <= '0;
        end else begin
            valid_q <= s2_valid_q;
            if (s2_valid_q) begin
                next_q <= next_d;
            end
        end
    end

    assign valid_o = valid_q;
    assign next_o  = next_q;

endmodule

// File: rtl/interpolator_intensity.sv
// Intensity interpolator: per-transducer current-value memory, CLEAR/RUN
// controller, index counter and S1 stage; S2/S3 live in interp_step.
// Optional build macro: SILENCER_BYPASS_EN (adds BYPASS input).
module interpolator_intensity #(
    parameter int DEPTH = 249
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        DIN_VALID,
    input  logic [15:0] INTENSITY,
    input  logic [15:0] UPDATE_RATE,
`ifdef SILENCER_BYPASS_EN
    input  logic        BYPASS,
`endif
    output logic        READY,
    output logic        DOUT_VALID,
    output logic [7:0]  DOUT_IDX,
    output logic [15:0] INTENSITY_S
);
    import silencer_pkg::*;

    localparam logic [7:0] LAST_IDX = 8'(DEPTH - 1);

    interp_state_t state_q, state_d;
    logic [7:0]    clr_cnt_q, clr_cnt_d;
    logic [7:0]    idx_q, idx_d;
    logic          accept;

    logic          s1_valid_q;
    intensity_t    s1_tgt_q;
    intensity_t    s1_rate_q;
    logic [7:0]    s1_idx_q;
`ifdef SILENCER_BYPASS_EN
    logic          s1_byp_q;
`endif
    logic          s2_valid_q;
    logic [7:0]    s2_idx_q;
    logic [7:0]    out_idx_q;

    intensity_t    mem_q [0:MEM_WORDS-1];
    intensity_t    rd_data_q;
    logic          wr_en;
    logic [7:0]    wr_addr;
    intensity_t    wr_data;

    logic          step_valid;
    intensity_t    step_next;

    assign accept = DIN_VALID && (state_q == RUN);
    assign READY  = (state_q == RUN);

    // Controller next state: sweep the clear counter, then count accepted entries.
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        idx_d     = idx_q;
        case (state_q)
            CLEAR: begin
                if (clr_cnt_q == LAST_IDX) begin
                    state_d   = RUN;
                    clr_cnt_d = '0;
                end else begin
                    clr_cnt_d = clr_cnt_q + 8'd1;
                end
            end
            RUN: begin
                if (accept) begin
                    idx_d = (idx_q == LAST_IDX) ? 8'd0 : (idx_q + 8'd1);
                end
            end
            default: state_d = CLEAR;
        endcase
    end

    // Controller state, counters and S1/index pipeline; reset drops in-flight entries.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q    <= CLEAR;
            clr_cnt_q  <= '0;
            idx_q      <= '0;
            s1_valid_q <= 1'b0;
            s1_tgt_q   <= '0;
            s1_rate_q  <= '0;
            s1_idx_q   <= '0;
`ifdef SILENCER_BYPASS_EN
            s1_byp_q   <= 1'b0;
`endif
            s2_valid_q <= 1'b0;
            s2_idx_q   <= '0;
            out_idx_q  <= '0;
        end else begin
            state_q    <= state_d;
            clr_cnt_q  <= clr_cnt_d;
            idx_q      <= idx_d;
            s1_valid_q <= accept;
            s1_tgt_q   <= INTENSITY;
            s1_rate_q  <= UPDATE_RATE;
            s1_idx_q   <= idx_q;
`ifdef SILENCER_BYPASS_EN
            s1_byp_q   <= BYPASS;
`endif
            s2_valid_q <= s1_valid_q;
            s2_idx_q   <= s1_idx_q;
            if (s2_valid_q) begin
                out_idx_q <= s2_idx_q;
            end
        end
    end

    // Single write port: zeros while clearing, otherwise the value leaving S3.
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = out_idx_q;
        wr_data = step_next;
        if (state_q == CLEAR) begin
            wr_en   = 1'b1;
            wr_addr = clr_cnt_q;
            wr_data = '0;
        end else if (step_valid) begin
            wr_en   = 1'b1;
        end
    end

    // Current-value memory with registered read addressed by the live index.
    always_ff @(posedge CLK) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
        rd_data_q <= mem_q[idx_q];
    end

    interp_step u_step (
        .clk       (CLK),
        .rst_n     (RST_N),
        .valid_i   (s1_valid_q),
        .current_i (rd_data_q),
        .target_i  (s1_tgt_q),
        .rate_i    (s1_rate_q),
`ifdef SILENCER_BYPASS_EN
        .bypass_i  (s1_byp_q),
`endif
        .valid_o   (step_valid),
        .next_o    (step_next)
    );

    assign DOUT_VALID  = step_valid;
    assign DOUT_IDX    = out_idx_q;
    assign INTENSITY_S = step_next;

endmodule
